// File: rtl/dram_burst_seq_if.sv
// dram_burst_seq_if: command, write-data, beat and read-data signals of the DRAM burst sequencer.
interface dram_burst_seq_if #(parameter int WORD_W = 32);
  logic              req_valid;
  logic              req_write;
  logic              req_bc4;
  logic              req_ready;
  logic              wdata_valid;
  logic [WORD_W-1:0] wdata;
  logic              wdata_ready;
  logic [WORD_W-1:0] memstore;
  logic [2:0]        COL_choice;
  logic              edge_flag;
  logic [WORD_W-1:0] memload;
  logic              rdata_valid;
  logic [WORD_W-1:0] rdata;
  logic              rdata_last;
  logic              rdata_ready;
  logic              busy;
  logic              done;
  modport master (
    output req_valid, req_write, req_bc4, wdata_valid, wdata, edge_flag, memload, rdata_ready,
    input  req_ready, wdata_ready, memstore, COL_choice, rdata_valid, rdata, rdata_last, busy, done
  );
  modport slave (
    input  req_valid, req_write, req_bc4, wdata_valid, wdata, edge_flag, memload, rdata_ready,
    output req_ready, wdata_ready, memstore, COL_choice, rdata_valid, rdata, rdata_last, busy, done
  );
endinterface

// File: rtl/dram_burst_seq.sv
// dram_burst_seq: single read/write DRAM burst sequencer; DRAM_BURST_CHOP_EN enables 4-beat burst chop via req_bc4.
module dram_burst_seq #(
  parameter int WORD_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int WR_LAT    = 4,
  parameter int RD_LAT    = 6
) (
  input logic CLK,
  input logic RST,
  dram_burst_seq_if.slave bus
);
  localparam int LAT_MAX = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
  localparam int LW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int IW      = $clog2(BURST_LEN);
  typedef enum logic [2:0] {IDLE, FILL, WR_WAIT, RD_WAIT, WR_BURST, RD_BURST, DRAIN, DONE} state_t;
  state_t            state, nxt;
  logic [LW-1:0]     lat;
  logic [2:0]        idx;
  logic [2:0]        last;
  logic              at_last;
  logic              adv;
  logic [WORD_W-1:0] mem [BURST_LEN];
`ifdef DRAM_BURST_CHOP_EN
  logic bc4;
  always_ff @(posedge CLK or posedge RST)
    if (RST) bc4 <= 1'b0;
    else if (state == IDLE && bus.req_valid) bc4 <= bus.req_bc4;
  assign last = bc4 ? 3'd3 : 3'(BURST_LEN - 1);
`else
  logic unused_bc4;
  assign unused_bc4 = bus.req_bc4;
  assign last = 3'(BURST_LEN - 1);
`endif
  assign at_last = (idx == last);
  // one index serves as fill pointer, beat and drain pointer; every phase ends by wrapping it to 0
  assign adv = (state == FILL && bus.wdata_valid) ||
               ((state == WR_BURST || state == RD_BURST) && bus.edge_flag) ||
               (state == DRAIN && bus.rdata_ready);
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = bus.req_valid ? (bus.req_write ? FILL : RD_WAIT) : IDLE;
      FILL:     nxt = (bus.wdata_valid && at_last) ? WR_WAIT : FILL;
      WR_WAIT:  nxt = (lat == '0) ? WR_BURST : WR_WAIT;
      RD_WAIT:  nxt = (lat == '0) ? RD_BURST : RD_WAIT;
      WR_BURST: nxt = (bus.edge_flag && at_last) ? DONE : WR_BURST;
      RD_BURST: nxt = (bus.edge_flag && at_last) ? DRAIN : RD_BURST;
      DRAIN:    nxt = (bus.rdata_ready && at_last) ? DONE : DRAIN;
      default:  nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready   = (state == IDLE);
    bus.wdata_ready = (state == FILL);
    bus.busy        = (state != IDLE);
    bus.done        = (state == DONE);
    bus.rdata_valid = (state == DRAIN);
    bus.rdata_last  = (state == DRAIN) && at_last;
    bus.rdata       = (state == DRAIN) ? mem[idx[IW-1:0]] : '0;
    bus.memstore    = (state == WR_BURST) ? mem[idx[IW-1:0]] : '0;
    bus.COL_choice  = (state == WR_BURST || state == RD_BURST) ? idx : 3'd0;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      idx <= 3'd0;
      lat <= '0;
    end else begin
      idx <= !adv ? idx : (at_last ? 3'd0 : idx + 3'd1);
      if (state == IDLE && bus.req_valid && !bus.req_write) lat <= LW'(RD_LAT - 1);
      else if (state == FILL && bus.wdata_valid && at_last) lat <= LW'(WR_LAT - 1);
      else if ((state == WR_WAIT || state == RD_WAIT) && lat != '0) lat <= lat - LW'(1);
    end
  always_ff @(posedge CLK)
    if (state == FILL && bus.wdata_valid) mem[idx[IW-1:0]] <= bus.wdata;
    else if (state == RD_BURST && bus.edge_flag) mem[idx[IW-1:0]] <= bus.memload;
endmodule

// File: tb/tb_dram_burst_seq.sv
// tb_dram_burst_seq: directed checks of write, read, backpressure, spurious strobes and mid-burst reset.
module tb_dram_burst_seq;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  dram_burst_seq_if #(.WORD_W(32)) bus ();
  dram_burst_seq #(.WORD_W(32), .BURST_LEN(8), .WR_LAT(4), .RD_LAT(6)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic int eff_len(input bit bc4);
`ifdef DRAM_BURST_CHOP_EN
    return bc4 ? 4 : 8;
`else
    return 8;
`endif
  endfunction
  task automatic check_idle_outputs(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " col"}, 32'(bus.COL_choice), 32'd0);
    check({tag, " rvalid"}, 32'(bus.rdata_valid), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
    check({tag, " wready"}, 32'(bus.wdata_ready), 32'd0);
    check({tag, " memstore"}, bus.memstore, 32'd0);
  endtask
  // abort < 0 runs the whole burst; otherwise stop after that many beats
  task automatic write_burst(input logic [31:0] base, input bit bc4, input int abort);
    int l = eff_len(bc4);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_bc4 = bc4;
    tick;
    bus.req_write = 1'b0;
    for (int i = 0; i < l; i++) begin
      check("fill wready", 32'(bus.wdata_ready), 32'd1);
      check("fill busy req_ready", 32'(bus.req_ready), 32'd0);
      bus.wdata_valid = 1'b1; bus.wdata = base + 32'(i);
      tick;
    end
    bus.wdata_valid = 1'b0; bus.req_valid = 1'b0;
    check("wready drop", 32'(bus.wdata_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("wait col", 32'(bus.COL_choice), 32'd0);
      bus.edge_flag = 1'b1;
      tick;
    end
    bus.edge_flag = 1'b0;
    for (int i = 0; i < l; i++) begin
      if (abort == i) return;
      check("wr memstore", bus.memstore, base + 32'(i));
      check("wr col", 32'(bus.COL_choice), 32'(i));
      check("wr done early", 32'(bus.done), 32'd0);
      if (i == 2) begin
        tick;
        check("wr hold col", 32'(bus.COL_choice), 32'd2);
      end
      bus.edge_flag = 1'b1;
      tick;
      bus.edge_flag = 1'b0;
    end
    check("wr done", 32'(bus.done), 32'd1);
    tick;
    check("wr done pulse", 32'(bus.done), 32'd0);
    check("wr back idle", 32'(bus.req_ready), 32'd1);
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_bc4 = 1'b0;
    bus.wdata_valid = 1'b0; bus.wdata = '0; bus.edge_flag = 1'b0;
    bus.memload = '0; bus.rdata_ready = 1'b0;
    #2;
    check_idle_outputs("reset");
    tick; tick;
    RST = 1'b0;
    tick;
    check_idle_outputs("post reset");
    write_burst(32'hA0, 1'b0, -1);
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    tick;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("rd wait col", 32'(bus.COL_choice), 32'd0);
      check("rd wait busy", 32'(bus.busy), 32'd1);
      bus.edge_flag = (i == 2);
      bus.memload = 32'hEE;
      tick;
    end
    for (int i = 0; i < 8; i++) begin
      check("rd col", 32'(bus.COL_choice), 32'(i));
      check("rd no valid", 32'(bus.rdata_valid), 32'd0);
      bus.memload = 32'h10 + 32'(i); bus.edge_flag = 1'b1;
      tick;
    end
    bus.edge_flag = 1'b0;
    bus.rdata_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        bus.rdata_ready = 1'b0;
        bus.edge_flag = 1'b1;
        for (int s = 0; s < 5; s++) begin
          tick;
          check("stall data", bus.rdata, 32'h13);
          check("stall valid", 32'(bus.rdata_valid), 32'd1);
          check("stall last", 32'(bus.rdata_last), 32'd0);
        end
        bus.edge_flag = 1'b0;
        bus.rdata_ready = 1'b1;
      end
      check("rd valid", 32'(bus.rdata_valid), 32'd1);
      check("rd data", bus.rdata, 32'h10 + 32'(i));
      check("rd last", 32'(bus.rdata_last), 32'(i == 7));
      tick;
    end
    bus.rdata_ready = 1'b0;
    check("rd done", 32'(bus.done), 32'd1);
    tick;
    check("rd done pulse", 32'(bus.done), 32'd0);
    check("rd idle", 32'(bus.req_ready), 32'd1);
    write_burst(32'hC0, 1'b0, 5);
    check("abort col", 32'(bus.COL_choice), 32'd5);
    #2;
    RST = 1'b1;
    #1;
    check_idle_outputs("mid reset");
    tick;
    RST = 1'b0;
    tick;
    check_idle_outputs("after mid reset");
    write_burst(32'hB0, 1'b0, -1);
    write_burst(32'hD0, 1'b1, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
